// File: rtl/mem_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_sequencer
//  Description : Sequences one load or store at a time onto a BUS_BYTES-wide
//                data-memory port. Accesses crossing a bus-word boundary are
//                split into two aligned beats with per-byte enables. Load
//                beats are merged into a right-aligned, optionally
//                sign-extended result.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                req_*                - request from execute (valid/ready)
//                flush                - abort current access
//                bus_*                - beat request / read return
//                rsp_*                - one-cycle completion pulse + status
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_sequencer #(
  parameter int BUS_BYTES   = 4,
  parameter int ADDR_W      = 32,
  parameter int ALLOW_SPLIT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_signed,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [8*BUS_BYTES-1:0] req_wdata,
  input  logic                   flush,
  output logic                   bus_valid,
  input  logic                   bus_ready,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic                   bus_re,
  output logic [BUS_BYTES-1:0]   bus_we,
  output logic [8*BUS_BYTES-1:0] bus_wdata,
  input  logic                   bus_rvalid,
  input  logic [8*BUS_BYTES-1:0] bus_rdata,
  output logic                   rsp_valid,
  output logic [8*BUS_BYTES-1:0] rsp_data,
  output logic                   rsp_err,
  output logic                   rsp_split
);

  localparam int         c_OFF_W = $clog2(BUS_BYTES);
  localparam int         c_DW    = 8 * BUS_BYTES;
  localparam logic [3:0] c_BB    = 4'(BUS_BYTES);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_B0    = 3'd1;
  localparam logic [2:0] c_R0    = 3'd2;
  localparam logic [2:0] c_B1    = 3'd3;
  localparam logic [2:0] c_R1    = 3'd4;
  localparam logic [2:0] c_DONE  = 3'd5;
  localparam logic [2:0] c_DRAIN = 3'd6;

  logic [2:0]        state_q, state_d;
  logic              we_q, sgn_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [c_DW-1:0]   wdata_q;
  logic [c_DW-1:0]   acc_q, acc_d;

  // Request-side decode, only consulted on the accept cycle.
  logic       w_accept, w_req_err;
  logic [3:0] w_req_off, w_req_n;
  assign w_accept  = (state_q == c_IDLE) && req_valid && !flush;
  assign w_req_off = 4'(req_addr[c_OFF_W-1:0]);
  assign w_req_n   = 4'd1 << req_size;
  assign w_req_err = (w_req_n > c_BB) ||
                     ((ALLOW_SPLIT == 0) && ((w_req_off + w_req_n) > c_BB));

  // Decode of the latched request; 4 bits covers off+n up to 15.
  logic [3:0]        w_off, w_n, w_end, w_k, w_n1;
  logic              w_split;
  logic [ADDR_W-1:0] w_base;
  assign w_off   = 4'(addr_q[c_OFF_W-1:0]);
  assign w_n     = 4'd1 << size_q;
  assign w_end   = w_off + w_n;
  assign w_split = w_end > c_BB;
  assign w_k     = c_BB - w_off;
  assign w_n1    = w_n - w_k;
  assign w_base  = {addr_q[ADDR_W-1:c_OFF_W], c_OFF_W'(0)};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          state_d = w_req_err ? c_DONE : c_B0;
          acc_d   = '0;
        end
      end
      c_B0: begin
        if (flush)          state_d = c_IDLE;
        else if (bus_ready) state_d = !we_q ? c_R0 : (w_split ? c_B1 : c_DONE);
      end
      c_R0: begin
        if (flush) begin
          state_d = bus_rvalid ? c_IDLE : c_DRAIN;
        end else if (bus_rvalid) begin
          state_d = w_split ? c_B1 : c_DONE;
          acc_d   = bus_rdata >> {w_off, 3'b000};
        end
      end
      c_B1: begin
        if (flush)          state_d = c_IDLE;
        else if (bus_ready) state_d = we_q ? c_DONE : c_R1;
      end
      c_R1: begin
        if (flush) begin
          state_d = bus_rvalid ? c_IDLE : c_DRAIN;
        end else if (bus_rvalid) begin
          state_d = c_DONE;
          acc_d   = acc_q | (bus_rdata << {w_k, 3'b000});
        end
      end
      c_DONE:  state_d = c_IDLE;
      c_DRAIN: if (bus_rvalid) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (w_accept) begin
        we_q    <= req_we;
        sgn_q   <= req_signed;
        err_q   <= w_req_err;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Bus side: everything is a function of registered state only.
  logic w_beat0, w_beat1;
  assign w_beat0   = (state_q == c_B0);
  assign w_beat1   = (state_q == c_B1);
  assign req_ready = (state_q == c_IDLE);
  assign bus_valid = w_beat0 || w_beat1;
  assign bus_re    = bus_valid && !we_q;
  assign bus_addr  = w_beat0 ? w_base :
                     w_beat1 ? (w_base + ADDR_W'(BUS_BYTES)) : '0;

  always_comb begin
    bus_we    = '0;
    bus_wdata = '0;
    if (we_q && w_beat0) bus_wdata = wdata_q << {w_off, 3'b000};
    if (we_q && w_beat1) bus_wdata = wdata_q >> {w_k, 3'b000};
    for (int i = 0; i < BUS_BYTES; i++) begin
      if (we_q && w_beat0 && (4'(i) >= w_off) && (4'(i) < w_end)) bus_we[i] = 1'b1;
      if (we_q && w_beat1 && (4'(i) < w_n1))                      bus_we[i] = 1'b1;
    end
  end

  // Response: flush in DONE suppresses the pulse.
  logic w_sign;
  assign rsp_valid = (state_q == c_DONE) && !flush;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_split = rsp_valid && w_split && !err_q;

  always_comb begin
    w_sign = 1'b0;
    for (int i = 0; i < BUS_BYTES; i++) begin
      if (4'(i + 1) == w_n) w_sign = acc_q[8*i+7];
    end
    rsp_data = '0;
    if (rsp_valid && !we_q && !err_q) begin
      for (int i = 0; i < BUS_BYTES; i++) begin
        rsp_data[8*i +: 8] = (4'(i) < w_n) ? acc_q[8*i +: 8] : {8{sgn_q & w_sign}};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_sequencer
//  Description : Directed self-checking bench for mem_access_sequencer
//                (BUS_BYTES=4), plus a second ALLOW_SPLIT=0 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_valid2, req_we, req_signed, flush;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  logic        req_ready, bus_valid, bus_re, rsp_valid, rsp_err, rsp_split;
  logic [31:0] bus_addr, bus_wdata, rsp_data;
  logic [3:0]  bus_we;

  logic        req_ready2, bus_valid2, bus_re2, rsp_valid2, rsp_err2, rsp_split2;
  logic [31:0] bus_addr2, bus_wdata2, rsp_data2;
  logic [3:0]  bus_we2;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_access_sequencer #(.BUS_BYTES(4), .ADDR_W(32), .ALLOW_SPLIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(flush),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_re(bus_re), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_split(rsp_split)
  );

  mem_access_sequencer #(.BUS_BYTES(4), .ADDR_W(32), .ALLOW_SPLIT(0)) u_dut_nosplit (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(1'b0),
    .bus_valid(bus_valid2), .bus_ready(1'b0), .bus_addr(bus_addr2),
    .bus_re(bus_re2), .bus_we(bus_we2), .bus_wdata(bus_wdata2),
    .bus_rvalid(1'b0), .bus_rdata(32'h0),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .rsp_err(rsp_err2),
    .rsp_split(rsp_split2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; returns in cycle T+1.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic split_load(input logic sgn, input logic [31:0] exp);
    bus_ready = 1'b1;
    issue(1'b0, 2'd1, sgn, 32'h0000_020F, 32'h0);
    chk("ld_b0_addr", bus_addr, 32'h0000_020C);
    chk("ld_b0_re", bus_re, 1'b1);
    chk("ld_b0_we", bus_we, 4'h0);
    step();                                    // R0
    chk("ld_r0_idle_bus", bus_valid, 1'b0);
    bus_rvalid = 1'b1; bus_rdata = 32'hAB00_0000;
    step();                                    // B1
    bus_rvalid = 1'b0;
    chk("ld_b1_addr", bus_addr, 32'h0000_0210);
    step();                                    // R1
    bus_rvalid = 1'b1; bus_rdata = 32'h0000_00F0;
    step();                                    // DONE
    bus_rvalid = 1'b0;
    chk("ld_rsp_valid", rsp_valid, 1'b1);
    chk("ld_rsp_data", rsp_data, exp);
    chk("ld_rsp_split", rsp_split, 1'b1);
    chk("ld_rsp_err", rsp_err, 1'b0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0; req_we = 1'b0;
    req_size = 2'd0; req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    flush = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    step(); step();
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    rst_n = 1'b1;
    step();

    // Aligned word store.
    bus_ready = 1'b1;
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    chk("st_valid_t1", bus_valid, 1'b1);
    chk("st_addr", bus_addr, 32'h0000_0100);
    chk("st_we", bus_we, 4'hF);
    chk("st_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("st_re", bus_re, 1'b0);
    step();
    chk("st_rsp_t2", rsp_valid, 1'b1);
    chk("st_split", rsp_split, 1'b0);
    chk("st_err", rsp_err, 1'b0);
    chk("st_rdata0", rsp_data, 32'h0);
    step();

    // Split word store at 0x103 with a stalled first beat.
    bus_ready = 1'b0;
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0103, 32'h1122_3344);
    chk("sp_b0_addr", bus_addr, 32'h0000_0100);
    chk("sp_b0_we", bus_we, 4'h8);
    chk("sp_b0_wdata", bus_wdata, 32'h4400_0000);
    step();
    chk("sp_b0_hold_addr", bus_addr, 32'h0000_0100);
    chk("sp_b0_hold_we", bus_we, 4'h8);
    bus_ready = 1'b1;
    step();
    chk("sp_b1_addr", bus_addr, 32'h0000_0104);
    chk("sp_b1_we", bus_we, 4'h7);
    chk("sp_b1_wdata", bus_wdata, 32'h0011_2233);
    step();
    chk("sp_rsp", rsp_valid, 1'b1);
    chk("sp_rsp_split", rsp_split, 1'b1);
    step();

    split_load(1'b1, 32'hFFFF_F0AB);
    split_load(1'b0, 32'h0000_F0AB);

    // Split load flushed in R0: rvalid swallowed, no beat 1, no response.
    bus_ready = 1'b1;
    issue(1'b0, 2'd1, 1'b1, 32'h0000_020F, 32'h0);
    step();                                    // R0
    flush = 1'b1;
    step();                                    // DRAIN
    flush = 1'b0;
    chk("fl_drain_busy", req_ready, 1'b0);
    chk("fl_drain_bus", bus_valid, 1'b0);
    bus_rvalid = 1'b1; bus_rdata = 32'hAB00_0000;
    step();
    bus_rvalid = 1'b0;
    chk("fl_ready_after", req_ready, 1'b1);
    chk("fl_no_rsp", rsp_valid, 1'b0);
    chk("fl_no_beat1", bus_valid, 1'b0);
    step();
    chk("fl_still_idle", bus_valid, 1'b0);

    // Wrap-around split store.
    bus_ready = 1'b1;
    issue(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'hAABB_CCDD);
    chk("wr_b0_addr", bus_addr, 32'hFFFF_FFFC);
    chk("wr_b0_we", bus_we, 4'hC);
    chk("wr_b0_wdata", bus_wdata, 32'hCCDD_0000);
    step();
    chk("wr_b1_addr", bus_addr, 32'h0000_0000);
    chk("wr_b1_we", bus_we, 4'h3);
    chk("wr_b1_wdata", bus_wdata, 32'h0000_AABB);
    step();
    chk("wr_rsp", rsp_valid, 1'b1);
    step();

    // Oversized access on a 4-byte bus.
    issue(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0);
    chk("sz_rsp_t1", rsp_valid, 1'b1);
    chk("sz_err", rsp_err, 1'b1);
    chk("sz_no_bus", bus_valid, 1'b0);
    chk("sz_split0", rsp_split, 1'b0);
    step();

    // Request together with flush in IDLE is not accepted.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h100;
    flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_bus", bus_valid, 1'b0);
    chk("idle_flush_ready", req_ready, 1'b1);

    // Misaligned word with splitting disabled.
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h0000_0101;
    req_valid2 = 1'b1;
    step();
    req_valid2 = 1'b0;
    chk("ns_rsp", rsp_valid2, 1'b1);
    chk("ns_err", rsp_err2, 1'b1);
    chk("ns_no_bus", bus_valid2, 1'b0);
    step();

    // Reset while in beat 1 of a split store.
    bus_ready = 1'b1;
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0103, 32'h1122_3344);
    step();
    chk("rb_in_b1", bus_we, 4'h7);
    rst_n = 1'b0;
    #1;
    chk("rb_bus_valid", bus_valid, 1'b0);
    chk("rb_bus_we", bus_we, 4'h0);
    chk("rb_bus_addr", bus_addr, 32'h0);
    chk("rb_req_ready", req_ready, 1'b1);
    chk("rb_rsp_valid", rsp_valid, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Parametrised memory-access sequencer between the execute stage and the data-memory port. It accepts one load or store at a time. Any access that crosses a bus-word boundary is split into two aligned bus beats with per-byte enables. Load beats are merged into one right-aligned, optionally sign-extended result. It generalises the fixed 32-bit, two-cycle misaligned path to `BUS_BYTES`-wide buses and adds a valid/ready bus handshake, flush and drain, and error reporting.

## Interface
Parameters:
- `BUS_BYTES`, 4: bus width in bytes; legal values 4 or 8.
- `ADDR_W`, 32: address width.
- `ALLOW_SPLIT`, 1: 1 = split misaligned accesses; 0 = report misaligned accesses as errors.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: access size; 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = 8 B.
- `req_signed` in 1: sign-extend load result.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 8*BUS_BYTES: store data, right-aligned.
- `flush` in 1: abort the current access (exception or rfe in writeback).
- `bus_valid` out 1: beat request.
- `bus_ready` in 1: beat accepted.
- `bus_addr` out ADDR_W: bus-aligned address.
- `bus_re` out 1: read beat.
- `bus_we` out BUS_BYTES: byte write enables.
- `bus_wdata` out 8*BUS_BYTES: lane-positioned write data.
- `bus_rvalid` in 1: read data returned.
- `bus_rdata` in 8*BUS_BYTES: read data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 8*BUS_BYTES: load result; 0 for stores.
- `rsp_err` out 1: size or misalignment error; qualified by `rsp_valid`.
- `rsp_split` out 1: access used two beats; qualified by `rsp_valid`.

## Operation
Derived values:
- `off` = low log2(BUS_BYTES) bits of the address.
- `n` = 2^size.
- `base` = address with `off` cleared.
- `split` = off + n > BUS_BYTES.
- `k` = BUS_BYTES − off, the number of bytes in beat 0.
- All address arithmetic is modulo 2^ADDR_W.

States:
- IDLE: `req_ready`=1. On `req_valid`, latch the request.
  - If n > BUS_BYTES, or (`split` and ALLOW_SPLIT=0): go to DONE with err=1 and no bus traffic.
  - Otherwise go to B0.
- B0: `bus_valid`=1, `bus_addr`=base.
  - Enables: bytes off..min(off+n, BUS_BYTES)−1.
  - Write data: `req_wdata` << 8·off.
  - On `bus_ready`: a load goes to R0; a split store goes to B1; otherwise go to DONE.
- R0: on `bus_rvalid`, capture `bus_rdata` >> 8·off into the low bytes. Go to B1 if split, else DONE.
- B1: `bus_addr`=base+BUS_BYTES.
  - Enables: bytes 0..n−k−1.
  - Write data: `req_wdata` >> 8·k.
  - On `bus_ready`: a load goes to R1; a store goes to DONE.
- R1: on `bus_rvalid`, OR `bus_rdata` << 8·k into the accumulator, then go to DONE.
- DONE: `rsp_valid`=1 for exactly one cycle, then go to IDLE.
  - `rsp_data` is the accumulator masked to n bytes.
  - The result is sign-extended from bit 8n−1 when `req_signed` is set.
- DRAIN: wait for `bus_rvalid`, discard it, then go to IDLE. No response is produced.

Bus output rules:
- `bus_re` = `bus_valid` && load.
- When `bus_valid`=0: `bus_we`, `bus_addr`, `bus_wdata` and `bus_re` are all 0.

Flush (priority over every other transition):
- In B0 or B1: go to IDLE. This applies even if `bus_ready` is high in the same cycle, so a split store never issues beat 1.
- In R0 or R1: go to DRAIN. If `bus_rvalid` is high in the same cycle, go straight to IDLE.
- In DONE: `rsp_valid` is suppressed.
- In DRAIN or IDLE: ignored. A request presented together with `flush` in IDLE is not accepted.

Reset: all state returns to IDLE asynchronously, and every output reads 0 except `req_ready`=1. An in-flight beat is abandoned. The bus is responsible for discarding outstanding rvalid across reset.

## Timing
- Request accepted at cycle T: `bus_valid` rises at T+1. Outputs are registered from state and do not depend combinationally on `req_*`.
- Aligned store with `bus_ready` at T+1: `rsp_valid` at T+2.
- Aligned load with `bus_rvalid` at T+2: `rsp_valid` at T+3.
- Split accesses add one beat plus the wait for `bus_ready` (and `bus_rvalid` for loads).
- Error responses: `rsp_valid` at T+1.
- `bus_*` outputs stay stable while `bus_valid`=1 and `bus_ready`=0.
- At most one read is outstanding at any time.
- The earliest re-accept is the cycle after DONE.

## Test plan
- BUS_BYTES=4, store w, addr 0x100, data 0xDEADBEEF: one beat at 0x100, we=1111, wdata 0xDEADBEEF; `rsp_valid` at T+2; split=0, err=0.
- Store w, addr 0x103, data 0x11223344:
  - beat 0: 0x100, we=1000, wdata 0x44000000;
  - beat 1: 0x104, we=0111, wdata 0x00112233;
  - `rsp_split`=1.
- Signed 2-byte load, addr 0x20F:
  - beat 0 at 0x20C returns rdata 0xAB000000;
  - beat 1 at 0x210 returns rdata 0x000000F0;
  - `rsp_data` = 0xFFFFF0AB; unsigned variant gives 0x0000F0AB.
- Split load with `flush` asserted in R0: the later `bus_rvalid` is swallowed, no `rsp_valid` occurs, no beat 1 is issued, and `req_ready`=1 the cycle after rvalid.
- Store w at 0xFFFFFFFE: beat 0 at 0xFFFFFFFC with we=1100; beat 1 at 0x00000000 with we=0011.
- Error and reset cases:
  - BUS_BYTES=4, size=3: `rsp_err`=1 at T+1 with no `bus_valid`.
  - ALLOW_SPLIT=0, word at 0x101: `rsp_err`=1.
  - `rst_n` low during B1: outputs zero immediately and `req_ready`=1.
